alu_muldiv: RTL and testbench

Parametrised execute-stage arithmetic unit for the MIPS pipeline. It extends the single-cycle ALU operation set to a configurable data width. It adds an iterative multiply/divide engine that writes dedicated HI/LO registers through a start/busy/done handshake. Combinational ops feed the EX-stage result mux in the same cycle. Multi-cycle ops stall the pipeline via `busy` until `done`.

---
 rtl/alu_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Execute-stage arithmetic unit: single-cycle ALU result on c, plus an
// iterative multiply/divide engine writing HI/LO through start/busy/done.
module alu_muldiv #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   input  logic             flush,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_MULT = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd13;
   localparam logic [3:0] OP_DIVU = 4'd14;

   localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t             state_q;
   logic [SHW-1:0]     cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               busy_q, done_q;
   logic               is_div_q;      // latched op class: divide vs multiply
   logic               neg_res_q;     // product / quotient must be negated
   logic               neg_rem_q;     // remainder takes the dividend's sign
   logic               dvz_q;         // divisor was zero
   logic [WIDTH-1:0]   mcand_q;       // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] prod_q;        // {upper, lower}: product or {rem, quotient}

   logic [SHW-1:0]     shamt;
   logic               md_op, md_signed, md_div;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_rext, div_diff;
   logic [2*WIDTH-1:0] prod_d;
   logic [WIDTH-1:0]   quo, rem, fix_hi_d, fix_lo_d;

   assign shamt     = a[SHW-1:0];
   assign md_op     = (op >= OP_MULT) && (op <= OP_DIVU);
   assign md_signed = (op == OP_MULT) || (op == OP_DIV);
   assign md_div    = (op == OP_DIV) || (op == OP_DIVU);
   assign mag_a     = (md_signed && a[WIDTH-1]) ? -a : a;
   assign mag_b     = (md_signed && b[WIDTH-1]) ? -b : b;

   // Single-cycle ALU result, depends only on the current op/a/b.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the case can leave it unassigned and infer a latch.
      c = '0;
      case (op)
         OP_ADD:  c = a + b;
         OP_SUB:  c = a - b;
         OP_AND:  c = a & b;
         OP_OR:   c = a | b;
         OP_XOR:  c = a ^ b;
         OP_NOR:  c = ~(a | b);
         OP_SLL:  c = b << shamt;
         OP_SRL:  c = b >> shamt;
         OP_SRA:  c = $unsigned($signed(b) >>> shamt);
         OP_SLT:  c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: c = {{(WIDTH-1){1'b0}}, (a < b)};
         default: c = '0;
      endcase
   end

   // One iteration step: shift-add multiply or restoring-subtract divide.
   always_comb begin
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      div_rext = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      div_diff = div_rext - {1'b0, mcand_q};
      if (!is_div_q) begin
         prod_d = {mul_sum, prod_q[WIDTH-1:1]};
      end else if (div_diff[WIDTH]) begin
         prod_d = {div_rext[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      end else begin
         prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      end
   end

   // Sign correction of the magnitude result, applied in the FIX state.
   always_comb begin
      quo = prod_q[WIDTH-1:0];
      rem = prod_q[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         fix_lo_d = dvz_q ? '1 : (neg_res_q ? -quo : quo);
         fix_hi_d = neg_rem_q ? -rem : rem;
      end else begin
         {fix_hi_d, fix_lo_d} = neg_res_q ? -prod_q : prod_q;
      end
   end

   // Control FSM with registered busy/done and the HI/LO result registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dvz_q     <= 1'b0;
         mcand_q   <= '0;
         prod_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start && md_op) begin
                     is_div_q  <= md_div;
                     neg_res_q <= md_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_rem_q <= md_signed && a[WIDTH-1];
                     dvz_q     <= (b == '0);
                     mcand_q   <= mag_b;
                     prod_q    <= {{WIDTH{1'b0}}, mag_a};
                     cnt_q     <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= S_RUN;
                  end
               end
               S_RUN: begin
                  prod_q <= prod_d;
                  if (cnt_q == LAST_STEP) begin
                     cnt_q   <= '0;
                     state_q <= S_FIX;
                  end else begin
                     cnt_q <= cnt_q + SHW'(1);
                  end
               end
               S_FIX: begin
                  hi_q    <= fix_hi_d;
                  lo_q    <= fix_lo_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;

   localparam int W = 32;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_MULT = 4'd11;
   localparam logic [3:0] OP_MULTU= 4'd12;
   localparam logic [3:0] OP_DIV  = 4'd13;
   localparam logic [3:0] OP_DIVU = 4'd14;
   localparam logic [3:0] OP_ZERO = 4'd15;

   logic         clk;
   logic         rst;
   logic [3:0]   op;
   logic [W-1:0] a, b;
   logic         start, flush;
   logic [W-1:0] c, hi, lo;
   logic         busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .op    (op),
      .a     (a),
      .b     (b),
      .start (start),
      .flush (flush),
      .c     (c),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      string        name;
   } vec_t;

   // Launch a multi-cycle op (caller is just past a negedge) and wait for done.
   // edges counts clock edges from the start-sampling edge (1) to the done edge.
   task automatic launch(input logic [3:0] f_op, input logic [W-1:0] f_a,
                         input logic [W-1:0] f_b, output int edges,
                         output int busy_cycles, output bit timed_out);
      op = f_op; a = f_a; b = f_b; start = 1'b1;
      edges = 0; busy_cycles = 0; timed_out = 1'b0;
      @(posedge clk); edges = 1;
      @(negedge clk); start = 1'b0;
      while (done !== 1'b1) begin
         if (busy === 1'b1) busy_cycles++;
         if (edges >= 100) begin
            timed_out = 1'b1;
            break;
         end
         @(posedge clk); edges++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; op = OP_ADD; a = '0; b = '0; start = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (hi !== '0) begin $display("FAIL reset_hi: got %h expected 0", hi); n_fail++; end
      n_checks++;
      if (lo !== '0) begin $display("FAIL reset_lo: got %h expected 0", lo); n_fail++; end
      n_checks++;
      if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy); n_fail++; end
      n_checks++;
      if (done !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", done); n_fail++; end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_comb();
      vec_t vecs[12];
      vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, "add_ovf"};
      vecs[1]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, "sub_wrap"};
      vecs[2]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and"};
      vecs[3]  = '{OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, "or"};
      vecs[4]  = '{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor"};
      vecs[5]  = '{OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, "nor"};
      vecs[6]  = '{OP_SLL,  32'h00000024, 32'h00000001, 32'h00000010, "sll_amt_mask"};
      vecs[7]  = '{OP_SRL,  32'h00000004, 32'h80000000, 32'h08000000, "srl"};
      vecs[8]  = '{OP_SRA,  32'h00000004, 32'h80000000, 32'hF8000000, "sra"};
      vecs[9]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt_neg"};
      vecs[10] = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, "sltu_big"};
      vecs[11] = '{OP_ZERO, 32'h00000005, 32'h00000006, 32'h00000000, "op15_zero"};
      for (int i = 0; i < 12; i++) begin
         op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
         #1;
         n_checks++;
         if (c !== vecs[i].exp) begin
            $display("FAIL comb_%s: got %h expected %h", vecs[i].name, c, vecs[i].exp);
            n_fail++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_mult();
      int edges, bc; bit to;
      @(negedge clk);
      launch(OP_MULT, 32'hFFFFFFFD, 32'd5, edges, bc, to);
      n_checks++;
      if (to) begin $display("FAIL mult_timeout: no done within 100 edges"); n_fail++; end
      n_checks++;
      if (edges !== 34) begin $display("FAIL mult_latency: got %0d edges expected 34", edges); n_fail++; end
      n_checks++;
      if (bc !== 33) begin $display("FAIL mult_busy_cycles: got %0d expected 33", bc); n_fail++; end
      n_checks++;
      if (busy !== 1'b0) begin $display("FAIL mult_busy_on_done: got %b expected 0", busy); n_fail++; end
      n_checks++;
      if (hi !== 32'hFFFFFFFF) begin $display("FAIL mult_hi: got %h expected ffffffff", hi); n_fail++; end
      n_checks++;
      if (lo !== 32'hFFFFFFF1) begin $display("FAIL mult_lo: got %h expected fffffff1", lo); n_fail++; end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin $display("FAIL mult_done_pulse: got %b expected 0", done); n_fail++; end
   endtask

   task automatic test_multu();
      int edges, bc; bit to;
      @(negedge clk);
      launch(OP_MULTU, 32'hFFFFFFFF, 32'd2, edges, bc, to);
      n_checks++;
      if (to) begin $display("FAIL multu_timeout: no done within 100 edges"); n_fail++; end
      n_checks++;
      if (hi !== 32'h00000001) begin $display("FAIL multu_hi: got %h expected 00000001", hi); n_fail++; end
      n_checks++;
      if (lo !== 32'hFFFFFFFE) begin $display("FAIL multu_lo: got %h expected fffffffe", lo); n_fail++; end
   endtask

   task automatic test_div();
      int edges, bc; bit to;
      @(negedge clk);
      launch(OP_DIV, 32'hFFFFFFF9, 32'd2, edges, bc, to);
      n_checks++;
      if (to) begin $display("FAIL div_timeout: no done within 100 edges"); n_fail++; end
      n_checks++;
      if (edges !== 34) begin $display("FAIL div_latency: got %0d edges expected 34", edges); n_fail++; end
      n_checks++;
      if (lo !== 32'hFFFFFFFD) begin $display("FAIL div_neg_lo: got %h expected fffffffd", lo); n_fail++; end
      n_checks++;
      if (hi !== 32'hFFFFFFFF) begin $display("FAIL div_neg_hi: got %h expected ffffffff", hi); n_fail++; end
      @(negedge clk);
      launch(OP_DIV, 32'd7, 32'hFFFFFFFE, edges, bc, to);
      n_checks++;
      if (lo !== 32'hFFFFFFFD) begin $display("FAIL div_negdivisor_lo: got %h expected fffffffd", lo); n_fail++; end
      n_checks++;
      if (hi !== 32'h00000001) begin $display("FAIL div_negdivisor_hi: got %h expected 00000001", hi); n_fail++; end
   endtask

   task automatic test_divu();
      int edges, bc; bit to;
      @(negedge clk);
      launch(OP_DIVU, 32'd7, 32'd2, edges, bc, to);
      n_checks++;
      if (to) begin $display("FAIL divu_timeout: no done within 100 edges"); n_fail++; end
      n_checks++;
      if (lo !== 32'd3) begin $display("FAIL divu_lo: got %h expected 00000003", lo); n_fail++; end
      n_checks++;
      if (hi !== 32'd1) begin $display("FAIL divu_hi: got %h expected 00000001", hi); n_fail++; end
   endtask

   task automatic test_div_edge();
      int edges, bc; bit to;
      @(negedge clk);
      launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF, edges, bc, to);
      n_checks++;
      if (lo !== 32'h80000000) begin $display("FAIL div_min_lo: got %h expected 80000000", lo); n_fail++; end
      n_checks++;
      if (hi !== 32'h00000000) begin $display("FAIL div_min_hi: got %h expected 00000000", hi); n_fail++; end
      @(negedge clk);
      launch(OP_DIVU, 32'd9, 32'd0, edges, bc, to);
      n_checks++;
      if (lo !== 32'hFFFFFFFF) begin $display("FAIL divu_zero_lo: got %h expected ffffffff", lo); n_fail++; end
      n_checks++;
      if (hi !== 32'd9) begin $display("FAIL divu_zero_hi: got %h expected 00000009", hi); n_fail++; end
      @(negedge clk);
      launch(OP_DIV, 32'hFFFFFFF7, 32'd0, edges, bc, to);
      n_checks++;
      if (lo !== 32'hFFFFFFFF) begin $display("FAIL div_zero_lo: got %h expected ffffffff", lo); n_fail++; end
      n_checks++;
      if (hi !== 32'hFFFFFFF7) begin $display("FAIL div_zero_hi: got %h expected fffffff7", hi); n_fail++; end
   endtask

   task automatic test_ignore_start();
      int edges;
      @(negedge clk);
      op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
      @(posedge clk); edges = 1;
      @(negedge clk); start = 1'b0;
      while (done !== 1'b1 && edges < 100) begin
         if (edges == 5) begin
            op = OP_MULTU; a = 32'd100; b = 32'd100; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); edges++;
         @(negedge clk);
      end
      start = 1'b0;
      n_checks++;
      if (edges !== 34) begin $display("FAIL ignore_latency: got %0d edges expected 34", edges); n_fail++; end
      n_checks++;
      if (hi !== 32'd0) begin $display("FAIL ignore_hi: got %h expected 00000000", hi); n_fail++; end
      n_checks++;
      if (lo !== 32'd42) begin $display("FAIL ignore_lo: got %h expected 0000002a", lo); n_fail++; end
   endtask

   task automatic test_back_to_back();
      int edges, bc; bit to;
      @(negedge clk);
      launch(OP_MULTU, 32'd3, 32'd4, edges, bc, to);
      n_checks++;
      if (lo !== 32'd12) begin $display("FAIL b2b_first_lo: got %h expected 0000000c", lo); n_fail++; end
      // Still in the done cycle: the next start must be accepted right away.
      launch(OP_DIVU, 32'd100, 32'd7, edges, bc, to);
      n_checks++;
      if (to) begin $display("FAIL b2b_timeout: no done within 100 edges"); n_fail++; end
      n_checks++;
      if (edges !== 34) begin $display("FAIL b2b_latency: got %0d edges expected 34", edges); n_fail++; end
      n_checks++;
      if (lo !== 32'd14) begin $display("FAIL b2b_second_lo: got %h expected 0000000e", lo); n_fail++; end
      n_checks++;
      if (hi !== 32'd2) begin $display("FAIL b2b_second_hi: got %h expected 00000002", hi); n_fail++; end
   endtask

   // hi/lo hold 2/14 from test_back_to_back on entry.
   task automatic test_flush();
      int dones;
      @(negedge clk);
      op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk); flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin $display("FAIL flush_busy: got %b expected 0", busy); n_fail++; end
      dones = 0;
      repeat (40) begin
         if (done === 1'b1) dones++;
         @(negedge clk);
      end
      n_checks++;
      if (dones !== 0) begin $display("FAIL flush_no_done: got %0d pulses expected 0", dones); n_fail++; end
      n_checks++;
      if (hi !== 32'd2) begin $display("FAIL flush_hi_hold: got %h expected 00000002", hi); n_fail++; end
      n_checks++;
      if (lo !== 32'd14) begin $display("FAIL flush_lo_hold: got %h expected 0000000e", lo); n_fail++; end
   endtask

   task automatic test_start_flush();
      int actives;
      @(negedge clk);
      op = OP_MULTU; a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0; flush = 1'b0;
      actives = 0;
      repeat (40) begin
         if (busy === 1'b1 || done === 1'b1) actives++;
         @(negedge clk);
      end
      n_checks++;
      if (actives !== 0) begin $display("FAIL start_flush_idle: got %0d active cycles expected 0", actives); n_fail++; end
      n_checks++;
      if (lo !== 32'd14) begin $display("FAIL start_flush_lo_hold: got %h expected 0000000e", lo); n_fail++; end
   endtask

   task automatic test_rst_mid();
      int dones, edges, bc; bit to;
      @(negedge clk);
      op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin $display("FAIL rst_pre_busy: got %b expected 1", busy); n_fail++; end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (hi !== 32'd0) begin $display("FAIL rst_async_hi: got %h expected 00000000", hi); n_fail++; end
      n_checks++;
      if (lo !== 32'd0) begin $display("FAIL rst_async_lo: got %h expected 00000000", lo); n_fail++; end
      n_checks++;
      if (busy !== 1'b0) begin $display("FAIL rst_async_busy: got %b expected 0", busy); n_fail++; end
      @(negedge clk); rst = 1'b0;
      dones = 0;
      repeat (40) begin
         if (done === 1'b1) dones++;
         @(negedge clk);
      end
      n_checks++;
      if (dones !== 0) begin $display("FAIL rst_no_done: got %0d pulses expected 0", dones); n_fail++; end
      launch(OP_MULTU, 32'd3, 32'd3, edges, bc, to);
      n_checks++;
      if (lo !== 32'd9) begin $display("FAIL rst_recover_lo: got %h expected 00000009", lo); n_fail++; end
   endtask

   initial begin
      test_reset();
      test_comb();
      test_mult();
      test_multu();
      test_div();
      test_divu();
      test_div_edge();
      test_ignore_start();
      test_back_to_back();
      test_flush();
      test_start_flush();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
